// File: rtl/cache_arbiter.sv
// Round-robin arbiter that serialises icache fills and dcache fills/writebacks
// onto one physical-memory port. Each request is latched at grant time.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    i_req;
  logic                    d_req;
  logic                    grant_i;
  logic                    grant_d;
  logic                    last_grant_d;  // 0: icache won last, 1: dcache won last
  logic                    op_write;
  logic                    serve_rd;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LINE_WIDTH-1:0]   wdata_r;
  logic [LINE_WIDTH-1:0]   line_r;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant_i = last_grant_d;
          grant_d = ~last_grant_d;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I: if (mem_resp) state_nxt = RESP_I;
      SERVE_D: if (mem_resp) state_nxt = RESP_D;
      RESP_I:  state_nxt = IDLE;
      RESP_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A read transaction is in flight on the memory port
  assign serve_rd = (state == SERVE_I) || ((state == SERVE_D) && !op_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_d <= 1'b0;
      op_write     <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      line_r       <= '0;
    end else begin
      if (grant_i) begin
        last_grant_d <= 1'b0;
        op_write     <= 1'b0;
        addr_r       <= i_pmem_addr;
      end
      if (grant_d) begin
        last_grant_d <= 1'b1;
        op_write     <= d_pmem_write;  // write wins when both strobes are high
        addr_r       <= d_pmem_addr;
        wdata_r      <= d_pmem_wdata;
      end
      if (serve_rd && mem_resp) line_r <= mem_rdata;
    end
  end

  // Memory side is decoded purely from state and latched registers
  assign mem_read     = serve_rd;
  assign mem_write    = (state == SERVE_D) && op_write;
  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign i_pmem_resp  = (state == RESP_I);
  assign d_pmem_resp  = (state == RESP_D);
  assign i_pmem_rdata = line_r;
  assign d_pmem_rdata = line_r;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates cacheline-granularity traffic from the instruction cache and the data cache onto the single physical-memory port. Sits directly downstream of the icache/dcache pair that serve the pipelined core: it accepts their miss fills and dirty writebacks, serialises them, and returns each line to its owner. Arbitration is round-robin on simultaneous requests. Every request is latched at grant, so the memory side sees stable signals for the whole transaction.

## Interface
Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- ADDR_WIDTH, 32, physical address width (line-aligned; low 5 bits passed through unchanged).

Ports:
- Clocking and reset: one clock (`clk`); reset (`rst`) is asynchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_pmem_read  in  1  icache line-fill request; held until i_pmem_resp.
- i_pmem_addr  in  ADDR_WIDTH  icache line address.
- i_pmem_rdata  out  LINE_WIDTH  fill data to icache; valid while i_pmem_resp=1.
- i_pmem_resp  out  1  one-cycle completion pulse to icache.
- d_pmem_read  in  1  dcache line-fill request; held until d_pmem_resp.
- d_pmem_write  in  1  dcache writeback request; held until d_pmem_resp.
- d_pmem_addr  in  ADDR_WIDTH  dcache line address.
- d_pmem_wdata  in  LINE_WIDTH  writeback data.
- d_pmem_rdata  out  LINE_WIDTH  fill data to dcache; valid while d_pmem_resp=1.
- d_pmem_resp  out  1  one-cycle completion pulse to dcache.
- mem_read  out  1  memory read strobe; held until mem_resp.
- mem_write  out  1  memory write strobe; held until mem_resp.
- mem_addr  out  ADDR_WIDTH  latched transaction address.
- mem_wdata  out  LINE_WIDTH  latched writeback data.
- mem_rdata  in  LINE_WIDTH  memory read data; valid with mem_resp.
- mem_resp  in  1  memory completion, one cycle.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- IDLE: icache request = i_pmem_read. dcache request = d_pmem_read | d_pmem_write.
  - Only one client requesting: grant it.
  - Both requesting: grant the client not recorded in last_grant.
  - On grant, latch addr and op into registers. For a dcache grant, also latch wdata.
  - On grant, set last_grant and go to SERVE_x.
  - For the dcache, d_pmem_write=1 with d_pmem_read=1 is treated as a write.
- SERVE_x: mem_read/mem_write are asserted from the latched op. mem_addr/mem_wdata come from the latched registers.
  - On mem_resp=1: capture mem_rdata into the line register (reads only) and go to RESP_x.
- RESP_x: assert x_pmem_resp=1 for exactly this cycle. x_pmem_rdata = line register. Next state is IDLE unconditionally.
- The RESP cycle guarantees the client has dropped its request before the next arbitration.
- mem_resp in IDLE/RESP_x is ignored. Client inputs are not sampled outside IDLE, so changes mid-transaction have no effect.
- Memory outputs are decoded only from the state and latched registers; there is no combinational path from client inputs to mem_*.
- x_pmem_rdata holds its last value outside the RESP cycle. Clients must only sample it with resp.

## Timing
- Reset (async, any state): state=IDLE, last_grant=I (dcache wins the first tie). All mem_* = 0, both resp = 0, line/addr/wdata registers = 0.
- Reset mid-transaction abandons it; no resp is issued.
- Cycle 0: request seen in IDLE.
- Cycle 1: mem_read/mem_write high.
- Cycle k: mem_resp high.
- Cycle k+1: client resp high.
- Cycle k+2: IDLE, new arbitration.
- Client-visible latency = memory latency + 2 cycles. Minimum transaction, with mem_resp in cycle 1, is 3 cycles from request to next IDLE.
- mem_read and mem_write are never both high. Both drop in the cycle after mem_resp.
- Back-to-back requests from both clients alternate I/D/I/D with no client serviced twice consecutively while the other waits.

## Test plan
- Reset with both clients requesting and mem_resp=1 → all outputs 0. After deassert, the first grant goes to the dcache: mem_addr=d_pmem_addr one cycle later.
- Icache read of addr 0x0000_1000 with memory returning 0xAAAA…A after 4 cycles → mem_read high cycles 1–4. i_pmem_resp high in cycle 5 only, with rdata=0xAAAA…A. mem_write stays 0 throughout.
- Dcache writeback of addr 0x8000_0040 with wdata=0x1234…; change d_pmem_wdata mid-transaction → mem_write stays high with the latched 0x1234… until mem_resp. d_pmem_resp pulses once.
- Both clients requesting continuously for 6 transactions → grant order D, I, D, I, D, I. Each resp pulse is exactly 1 cycle, with one RESP cycle and one IDLE cycle between transactions.
- Stray mem_resp in IDLE and RESP → no state change and no client resp.
- Assert rst asynchronously mid-SERVE_D → outputs clear before the next edge, no d_pmem_resp, and the arbiter restarts from IDLE.
